alu_flags_n: RTL
================

ALU_FLAGS_N -- requirements
Module: alu_flags_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (legal range 4..32).
REQ-002 SHALL have parameter OP_W, default 3, opcode width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port a, input, WIDTH, operand A.
REQ-006 SHALL have port b, input, WIDTH, operand B.
REQ-007 SHALL have port op, input, OP_W, operation select; encodings per REQ-035.
REQ-008 SHALL have port start, input, 1, executes op on a/b at this edge.
REQ-009 SHALL have port out_en, input, 1, active-low bus-drive enable.
REQ-010 SHALL have port out, output, WIDTH, tri-state bus output of the result register.
REQ-011 SHALL have port valid, output, 1, one-cycle pulse marking a new result/flag set.
REQ-012 SHALL have ports flag_c, flag_z, flag_n, flag_v, output, 1 each: registered carry, zero, negative, signed overflow.

Function
REQ-013 SHALL have latency 1: with start high at edge k, result and flags SHALL update at edge k, and valid SHALL be high from edge k to edge k+1.
REQ-014 With start low, result, flags and valid=0 SHALL hold; a/b/op SHALL be ignored.
REQ-015 Back-to-back start on consecutive edges SHALL be accepted every cycle, valid staying high.
REQ-016 ADD: result = a + b; C = carry out of bit WIDTH-1.
REQ-017 ADC: result = a + b + C(previous); C = carry out.
REQ-018 SUB: result = a + ~b + 1; C = 1 means no borrow (a >= b unsigned).
REQ-019 SBB: result = a + ~b + C(previous); C as in SUB, for multi-word subtraction.
REQ-020 CMP: computes SUB; flags update; result register SHALL NOT change.
REQ-021 AND, OR, XOR: bitwise result; C SHALL hold its previous value; V SHALL be cleared.
REQ-022 Z SHALL be 1 iff the WIDTH-bit computed value (CMP: the difference) is zero; N SHALL equal its bit WIDTH-1.
REQ-023 V SHALL be set iff the signed result of an arithmetic op is not representable in WIDTH bits (operand signs equal for the effective addend, result sign differs).
REQ-024 All arithmetic SHALL be modulo 2^WIDTH; the carry into ADC/SBB SHALL be the C flag registered before the current edge.
REQ-025 out SHALL equal the result register when out_en = 0 and SHALL be high-impedance on every bit when out_en = 1; out_en SHALL be combinational to out and SHALL NOT affect state.
REQ-026 Undefined op encodings SHALL behave as start low: no state change, valid = 0.

Reset
REQ-027 With rst high at an edge, result, flag_c, flag_z, flag_n, flag_v and valid SHALL all be 0 after that edge.
REQ-028 rst SHALL take priority over start at the same edge; the operation SHALL be discarded.
REQ-029 A chained ADC/SBB sequence interrupted by rst SHALL resume with C = 0.
REQ-030 out SHALL remain governed solely by out_en during and after reset (driving 0 when enabled).

Structure
REQ-031 Opcode encodings and WIDTH-independent constants SHALL live in the shared package alu_pkg.
REQ-032 The adder SHALL be one sub-module, adder_ripple_nbit (parameter WIDTH; a, b, cin -> sum, cout), used for all arithmetic ops.
REQ-033 Subtraction SHALL be formed by inverting b and driving cin; no separate subtractor.
REQ-034 Result and flag registers SHALL be in alu_flags_n; no latches.
REQ-035 alu_pkg encodings: ADD=0, ADC=1, SUB=2, SBB=3, CMP=4, AND=5, OR=6, XOR=7.

Verification (WIDTH=8)
REQ-036 rst high 1 cycle, out_en=0 -> out=0x00, all flags 0, valid 0.
REQ-037 ADD 0x7F,0x01 -> out=0x80, N=1, V=1, C=0, Z=0, valid pulse 1 cycle.
REQ-038 ADD 0xFF,0x01 then ADC 0x12,0x34 -> 0x00 (C=1, Z=1), then 0x47 (C=0).
REQ-039 SUB 0x05,0x05 -> 0x00, Z=1, C=1; then CMP 0x03,0x04 -> out stays 0x00, C=0, N=1, Z=0.
REQ-040 start and rst high at same edge with ADD 0x10,0x20 -> out=0x00, flags 0, valid 0.
REQ-041 result 0x47, toggle out_en 0->1->0 with start low -> out 0x47, all Z, 0x47; no flag/valid change.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the flag-producing ALU.
package alu_pkg;

    localparam int OP_ENC_W = 3;

    localparam logic [OP_ENC_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_ENC_W-1:0] OP_ADC = 3'd1;
    localparam logic [OP_ENC_W-1:0] OP_SUB = 3'd2;
    localparam logic [OP_ENC_W-1:0] OP_SBB = 3'd3;
    localparam logic [OP_ENC_W-1:0] OP_CMP = 3'd4;
    localparam logic [OP_ENC_W-1:0] OP_AND = 3'd5;
    localparam logic [OP_ENC_W-1:0] OP_OR  = 3'd6;
    localparam logic [OP_ENC_W-1:0] OP_XOR = 3'd7;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_CLEAR = '{c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};

endpackage

// File: rtl/adder_ripple_nbit.sv
// Ripple-carry adder shared by every arithmetic operation of the ALU.
module adder_ripple_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic carry;

    // Carry is walked bit by bit inside one process so the chain stays a single combinational path.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/alu_flags_n.sv
// Single-cycle ALU with registered result/flags, carry chaining and a tri-state result bus.
module alu_flags_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             start,
    input  logic             out_en,
    output tri logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    logic [WIDTH-1:0] result_q;
    alu_flags_t       flags_q;
    logic             valid_q;

    logic             exec;
    logic             is_arith;
    logic             write_result;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] next_val;
    alu_flags_t       next_flags;

    // Subtraction reuses the adder: b is inverted and the carry-in supplies the +1 (or the chained borrow).
    always_comb begin
        exec         = start;
        is_arith     = 1'b0;
        write_result = 1'b1;
        add_b        = b;
        add_cin      = 1'b0;
        logic_res    = '0;
        case (op)
            OP_W'(OP_ADD): begin
                is_arith = 1'b1;
            end
            OP_W'(OP_ADC): begin
                is_arith = 1'b1;
                add_cin  = flags_q.c;
            end
            OP_W'(OP_SUB): begin
                is_arith = 1'b1;
                add_b    = ~b;
                add_cin  = 1'b1;
            end
            OP_W'(OP_SBB): begin
                is_arith = 1'b1;
                add_b    = ~b;
                add_cin  = flags_q.c;
            end
            OP_W'(OP_CMP): begin
                is_arith     = 1'b1;
                write_result = 1'b0;
                add_b        = ~b;
                add_cin      = 1'b1;
            end
            OP_W'(OP_AND): logic_res = a & b;
            OP_W'(OP_OR):  logic_res = a | b;
            OP_W'(OP_XOR): logic_res = a ^ b;
            default: exec = 1'b0;
        endcase
    end

    adder_ripple_nbit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    // Overflow compares the sign of a against the effective addend, so it is correct for SUB/SBB/CMP too.
    always_comb begin
        next_val     = is_arith ? sum : logic_res;
        next_flags.c = is_arith ? cout : flags_q.c;
        next_flags.z = (next_val == '0);
        next_flags.n = next_val[WIDTH-1];
        next_flags.v = is_arith & (a[WIDTH-1] == add_b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= FLAGS_CLEAR;
            valid_q  <= 1'b0;
        end else if (exec) begin
            if (write_result) begin
                result_q <= next_val;
            end
            flags_q <= next_flags;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign out    = out_en ? {WIDTH{1'bz}} : result_q;
    assign valid  = valid_q;
    assign flag_c = flags_q.c;
    assign flag_z = flags_q.z;
    assign flag_n = flags_q.n;
    assign flag_v = flags_q.v;

endmodule
